// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_responder
// Purpose  : SPI Mode 0 responder emulating a serial flash. Decodes READ
//            (0x03: 24-bit address, then streamed bytes) and READ STATUS
//            (0x05: returns 0x00 forever). Data bytes are fetched over a
//            single-outstanding request/acknowledge memory port.
// Ports    : clk, reset (sync, active-low)
//            i_SPI_CLK / i_SPI_MOSI / i_SPI_CS  - raw SPI pins (oversampled)
//            o_SPI_MISO / o_SPI_MISO_OE         - responder data and enable
//            o_MEM_ADDR / o_MEM_REQ             - fetch address and request
//            i_MEM_DATA / i_MEM_ACK             - fetched byte and acknowledge
//            o_BUSY                             - synchronized CS is low
//            o_UNDERRUN                         - byte not ready at boundary
// Revision : 1.0  initial release
// ============================================================================
module spi_flash_responder #(
    parameter int MEM_AW      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_SPI_CLK,
    input  logic              i_SPI_MOSI,
    input  logic              i_SPI_CS,
    output logic              o_SPI_MISO,
    output logic              o_SPI_MISO_OE,
    output logic [MEM_AW-1:0] o_MEM_ADDR,
    output logic              o_MEM_REQ,
    input  logic [7:0]        i_MEM_DATA,
    input  logic              i_MEM_ACK,
    output logic              o_BUSY,
    output logic              o_UNDERRUN
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_STATUS = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

    localparam logic [7:0]        c_CMD_READ   = 8'h03;
    localparam logic [7:0]        c_CMD_STATUS = 8'h05;
    localparam logic [MEM_AW-1:0] c_ADDR_ONE   = {{(MEM_AW-1){1'b0}}, 1'b1};

    state_t                   state_q,      state_d;
    logic [SYNC_STAGES-1:0]   sclk_sync_q,  sclk_sync_d;
    logic [SYNC_STAGES-1:0]   mosi_sync_q,  mosi_sync_d;
    logic [SYNC_STAGES-1:0]   cs_sync_q,    cs_sync_d;
    logic                     sclk_prev_q,  sclk_prev_d;
    logic                     cs_prev_q,    cs_prev_d;
    logic [4:0]               bit_cnt_q,    bit_cnt_d;
    logic [2:0]               out_cnt_q,    out_cnt_d;
    logic [6:0]               cmd_sh_q,     cmd_sh_d;
    logic [MEM_AW-2:0]        addr_sh_q,    addr_sh_d;
    logic [7:0]               tx_sh_q,      tx_sh_d;
    logic                     miso_q,       miso_d;
    logic                     oe_q,         oe_d;
    logic [MEM_AW-1:0]        fetch_addr_q, fetch_addr_d;
    logic [MEM_AW-1:0]        mem_addr_q,   mem_addr_d;
    logic                     req_q,        req_d;
    logic                     fetch_pend_q, fetch_pend_d;
    logic                     discard_q,    discard_d;
    logic [7:0]               buf_data_q,   buf_data_d;
    logic                     buf_valid_q,  buf_valid_d;
    logic                     underrun_q,   underrun_d;

    logic w_sclk_s, w_mosi_s, w_cs_s;
    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

    assign w_sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign w_mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign w_cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~sclk_prev_q;
    assign w_sclk_fall = ~w_sclk_s & sclk_prev_q;
    assign w_cs_rise   = w_cs_s & ~cs_prev_q;
    assign w_cs_fall   = ~w_cs_s & cs_prev_q;

    always_comb begin
        state_d      = state_q;
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], i_SPI_CLK};
        mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_MOSI};
        cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], i_SPI_CS};
        sclk_prev_d  = w_sclk_s;
        cs_prev_d    = w_cs_s;
        bit_cnt_d    = bit_cnt_q;
        out_cnt_d    = out_cnt_q;
        cmd_sh_d     = cmd_sh_q;
        addr_sh_d    = addr_sh_q;
        tx_sh_d      = tx_sh_q;
        miso_d       = miso_q;
        oe_d         = oe_q;
        fetch_addr_d = fetch_addr_q;
        req_d        = req_q;
        fetch_pend_d = fetch_pend_q;
        discard_d    = discard_q;
        buf_data_d   = buf_data_q;
        buf_valid_d  = buf_valid_q;
        underrun_d   = 1'b0;

        // Memory port: complete the outstanding fetch, or launch a pending one.
        if (req_q && i_MEM_ACK) begin
            req_d     = 1'b0;
            discard_d = 1'b0;
            if (!discard_q) begin
                buf_data_d  = i_MEM_DATA;
                buf_valid_d = 1'b1;
            end
        end else if (!req_q && fetch_pend_q) begin
            req_d        = 1'b1;
            fetch_pend_d = 1'b0;
        end

        if (w_cs_rise) begin
            // CS rise has priority over any SCLK edge seen in the same cycle.
            state_d      = ST_IDLE;
            oe_d         = 1'b0;
            miso_d       = 1'b1;
            bit_cnt_d    = 5'd0;
            out_cnt_d    = 3'd0;
            buf_valid_d  = 1'b0;
            fetch_pend_d = 1'b0;
            // A fetch still in flight must finish its handshake, but its
            // data belongs to the aborted transaction.
            if (req_q && !i_MEM_ACK) begin
                discard_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 5'd0;
                    end
                end
                ST_CMD: begin
                    if (w_sclk_rise) begin
                        cmd_sh_d  = {cmd_sh_q[5:0], w_mosi_s};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            out_cnt_d = 3'd0;
                            if ({cmd_sh_q, w_mosi_s} == c_CMD_READ) begin
                                state_d = ST_ADDR;
                            end else if ({cmd_sh_q, w_mosi_s} == c_CMD_STATUS) begin
                                state_d = ST_STATUS;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_sclk_rise) begin
                        // Only the low MEM_AW address bits are kept.
                        addr_sh_d = {addr_sh_q[MEM_AW-3:0], w_mosi_s};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            fetch_addr_d = {addr_sh_q, w_mosi_s};
                            fetch_pend_d = 1'b1;
                            bit_cnt_d    = 5'd0;
                            out_cnt_d    = 3'd0;
                            state_d      = ST_DATA;
                        end
                    end
                end
                ST_DATA, ST_STATUS: begin
                    if (w_sclk_fall) begin
                        out_cnt_d = out_cnt_q + 3'd1;
                        if (out_cnt_q == 3'd0) begin
                            oe_d = 1'b1;
                            if (state_q == ST_STATUS) begin
                                miso_d  = 1'b0;
                                tx_sh_d = 8'h01;
                            end else if (buf_valid_q) begin
                                miso_d       = buf_data_q[7];
                                tx_sh_d      = {buf_data_q[6:0], 1'b1};
                                buf_valid_d  = 1'b0;
                                fetch_addr_d = fetch_addr_q + c_ADDR_ONE;
                                fetch_pend_d = 1'b1;
                            end else begin
                                // Underrun: the pending fetch stays in flight
                                // and its data serves the following byte.
                                miso_d     = 1'b1;
                                tx_sh_d    = 8'hFF;
                                underrun_d = 1'b1;
                            end
                        end else begin
                            miso_d  = tx_sh_q[7];
                            tx_sh_d = {tx_sh_q[6:0], 1'b1};
                        end
                    end
                end
                default: begin
                    // ST_IGNORE: wait silently for CS to deassert.
                end
            endcase
        end

        // The address tracks the next fetch target but is frozen while a
        // request is outstanding.
        mem_addr_d = req_q ? mem_addr_q : fetch_addr_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            sclk_sync_q  <= '0;
            mosi_sync_q  <= '0;
            cs_sync_q    <= '1;
            sclk_prev_q  <= 1'b0;
            cs_prev_q    <= 1'b1;
            bit_cnt_q    <= 5'd0;
            out_cnt_q    <= 3'd0;
            cmd_sh_q     <= '0;
            addr_sh_q    <= '0;
            tx_sh_q      <= 8'hFF;
            miso_q       <= 1'b1;
            oe_q         <= 1'b0;
            fetch_addr_q <= '0;
            mem_addr_q   <= '0;
            req_q        <= 1'b0;
            fetch_pend_q <= 1'b0;
            discard_q    <= 1'b0;
            buf_data_q   <= 8'h00;
            buf_valid_q  <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sclk_sync_q  <= sclk_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            cs_sync_q    <= cs_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            cs_prev_q    <= cs_prev_d;
            bit_cnt_q    <= bit_cnt_d;
            out_cnt_q    <= out_cnt_d;
            cmd_sh_q     <= cmd_sh_d;
            addr_sh_q    <= addr_sh_d;
            tx_sh_q      <= tx_sh_d;
            miso_q       <= miso_d;
            oe_q         <= oe_d;
            fetch_addr_q <= fetch_addr_d;
            mem_addr_q   <= mem_addr_d;
            req_q        <= req_d;
            fetch_pend_q <= fetch_pend_d;
            discard_q    <= discard_d;
            buf_data_q   <= buf_data_d;
            buf_valid_q  <= buf_valid_d;
            underrun_q   <= underrun_d;
        end
    end

    assign o_SPI_MISO    = miso_q;
    assign o_SPI_MISO_OE = oe_q;
    assign o_MEM_ADDR    = mem_addr_q;
    assign o_MEM_REQ     = req_q;
    assign o_BUSY        = ~w_cs_s;
    assign o_UNDERRUN    = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_responder
// Purpose  : Self-checking bench for spi_flash_responder. Acts as SPI master
//            and as the memory behind the fetch port; expected bytes and
//            fetch addresses come from a simple address->byte memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_flash_responder;

    localparam int MEM_AW = 12;
    localparam int SYNC   = 2;
    localparam int DEPTH  = 1 << MEM_AW;

    logic              clk = 1'b0;
    logic              reset;
    logic              sclk, mosi, cs;
    logic              miso, miso_oe;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_req;
    logic [7:0]        mem_data;
    logic              mem_ack;
    logic              busy, underrun;

    always #5 clk = ~clk;

    spi_flash_responder #(.MEM_AW(MEM_AW), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_SPI_CLK    (sclk),
        .i_SPI_MOSI   (mosi),
        .i_SPI_CS     (cs),
        .o_SPI_MISO   (miso),
        .o_SPI_MISO_OE(miso_oe),
        .o_MEM_ADDR   (mem_addr),
        .o_MEM_REQ    (mem_req),
        .i_MEM_DATA   (mem_data),
        .i_MEM_ACK    (mem_ack),
        .o_BUSY       (busy),
        .o_UNDERRUN   (underrun)
    );

    int         checks   = 0;
    int         failures = 0;
    int         hp        = 6;     // SCLK half period in clk cycles
    int         ack_delay = 2;     // cycles from REQ seen to ACK
    logic [7:0] salt      = 8'h00; // memory content = low address byte ^ salt
    logic [7:0] rx_q[$];
    int         req_log[$];        // written only by the memory responder
    int         hold_bad = 0;      // address changed while REQ pending
    int         ucnt     = 0;      // underrun pulses seen
    bit         oe_lo_seen, oe_hi_seen, busy_lo_seen;

    function automatic logic [7:0] mem_byte(input int a);
        logic [7:0] lo;
        lo = a[7:0];
        return lo ^ salt;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (underrun === 1'b1) ucnt++;
    end

    // Memory model: acknowledges each request after ack_delay cycles.
    initial begin : responder
        int a;
        bit live;
        mem_ack  = 1'b0;
        mem_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (mem_req === 1'b1 && reset === 1'b1) begin
                a = int'(mem_addr);
                req_log.push_back(a);
                live = 1'b1;
                for (int i = 0; i < ack_delay; i++) begin
                    @(posedge clk); #1;
                    if (mem_req !== 1'b1) begin
                        live = 1'b0;
                        break;
                    end
                    if (int'(mem_addr) != a) hold_bad++;
                end
                if (live) begin
                    mem_data = mem_byte(a);
                    mem_ack  = 1'b1;
                    @(posedge clk); #1;
                    mem_ack  = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // One SCLK period; finish raises CS while SCLK is still high.
    task automatic spi_bit(input logic b, input bit data_ph, input bit finish, output logic r);
        mosi = b;
        repeat (hp) @(posedge clk); #1;
        sclk = 1'b1;
        r = miso;
        if (data_ph) begin
            if (miso_oe !== 1'b1) oe_lo_seen = 1'b1;
            else oe_hi_seen = 1'b1;
        end
        if (busy !== 1'b1) busy_lo_seen = 1'b1;
        repeat (hp) @(posedge clk); #1;
        if (finish) begin
            cs = 1'b1;
            repeat (SYNC + 4) @(posedge clk); #1;
        end
        sclk = 1'b0;
    endtask

    task automatic spi_txn(input logic [7:0] cmd, input logic [23:0] addr,
                           input int abits, input int nbytes);
        logic r;
        logic [7:0] rb;
        int total;
        rx_q.delete();
        oe_lo_seen   = 1'b0;
        oe_hi_seen   = 1'b0;
        busy_lo_seen = 1'b0;
        rb = 8'h00;
        total = 8 + abits + 8 * nbytes;
        cs = 1'b0;
        for (int i = 0; i < 8; i++) spi_bit(cmd[7-i], 1'b0, (i == total - 1), r);
        for (int i = 0; i < abits; i++) spi_bit(addr[23-i], 1'b0, (8 + i == total - 1), r);
        for (int k = 0; k < nbytes; k++) begin
            for (int j = 0; j < 8; j++) begin
                spi_bit(1'b0, 1'b1, (8 + abits + 8 * k + j == total - 1), r);
                rb = {rb[6:0], r};
            end
            rx_q.push_back(rb);
        end
        repeat (12) @(posedge clk); #1;
    endtask

    task automatic run_read(input logic [23:0] addr, input int n, input bit late);
        int base_req, base_u, a0, exp_nreq;
        logic [7:0] e;
        base_req = req_log.size();
        base_u   = ucnt;
        spi_txn(8'h03, addr, 24, n);
        a0 = int'(addr[MEM_AW-1:0]);
        for (int k = 0; k < n; k++) begin
            if (late) e = (k == 0) ? 8'hFF : mem_byte((a0 + k - 1) % DEPTH);
            else      e = mem_byte((a0 + k) % DEPTH);
            check("rd_byte", rx_q[k], e);
        end
        check("rd_oe", oe_lo_seen, 0);
        check("rd_busy", busy_lo_seen, 0);
        exp_nreq = late ? n : n + 1;
        check("rd_nreq", req_log.size() - base_req, exp_nreq);
        for (int i = 0; i < exp_nreq && base_req + i < req_log.size(); i++)
            check("rd_req_addr", req_log[base_req + i], (a0 + i) % DEPTH);
        check("rd_underrun", ucnt - base_u, late ? 1 : 0);
    endtask

    initial begin : main
        logic r;
        logic [23:0] ra;
        int base;
        cs = 1'b1; sclk = 1'b0; mosi = 1'b0; reset = 1'b0;
        repeat (5) @(posedge clk); #1;
        check("rst_miso", miso, 1);
        check("rst_oe", miso_oe, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        reset = 1'b1;
        repeat (5) @(posedge clk); #1;

        // Basic read, memory returns low address byte
        hp = 8; ack_delay = 2; salt = 8'h00;
        run_read(24'h000123, 4, 1'b0);

        // Address wrap with upper bits ignored
        hp = 7; salt = 8'h5A;
        run_read(24'hABCFFF, 2, 1'b0);

        // READ STATUS
        hp = 6;
        base = req_log.size();
        spi_txn(8'h05, 24'h0, 0, 3);
        for (int k = 0; k < 3; k++) check("st_byte", rx_q[k], 8'h00);
        check("st_oe", oe_lo_seen, 0);
        check("st_nreq", req_log.size() - base, 0);

        // Unknown command is ignored, then a normal read
        base = req_log.size();
        spi_txn(8'hAB, 24'h0, 0, 2);
        check("ign_oe", oe_hi_seen, 0);
        check("ign_nreq", req_log.size() - base, 0);
        salt = 8'hC3;
        run_read(24'h000010, 1, 1'b0);

        // First byte late -> 0xFF, late data used for the second byte
        hp = 6; ack_delay = 2 * hp + 4; salt = 8'h3C;
        ra = 24'($urandom());
        run_read(ra, 3, 1'b1);
        repeat (60) @(posedge clk); #1;
        ack_delay = 2;

        // Abort during address phase
        base = req_log.size();
        spi_txn(8'h03, 24'h123456, 20, 0);
        check("abort_busy", busy, 0);
        check("abort_oe", miso_oe, 0);
        check("abort_miso", miso, 1);
        check("abort_nreq", req_log.size() - base, 0);

        // Reset during DATA with a request outstanding
        ack_delay = 500;
        cs = 1'b0;
        for (int i = 0; i < 8; i++) spi_bit(((8'h03 >> (7 - i)) & 8'h01) != 0, 1'b0, 1'b0, r);
        for (int i = 0; i < 24; i++) spi_bit(i[0], 1'b0, 1'b0, r);
        repeat (6) @(posedge clk); #1;
        check("mid_req_high", mem_req, 1);
        reset = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_oe", miso_oe, 0);
        check("mid_rst_miso", miso, 1);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_busy", busy, 0);
        cs = 1'b1; sclk = 1'b0;
        repeat (2) @(posedge clk); #1;
        reset = 1'b1;
        ack_delay = 2;
        repeat (10) @(posedge clk); #1;
        salt = 8'h11;
        run_read(24'h000FFE, 3, 1'b0);

        // Randomized reads
        for (int t = 0; t < 6; t++) begin
            hp        = int'($urandom_range(6, 10));
            ack_delay = int'($urandom_range(0, 2));
            salt      = 8'($urandom());
            ra        = 24'($urandom());
            run_read(ra, int'($urandom_range(1, 4)), 1'b0);
        end

        check("req_addr_stable", hold_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_flash_responder.md
# spi_flash_responder

SPI Mode 0 responder (slave) that emulates a serial flash for the 6809 system's SPI flash read path. It decodes the READ (0x03) command, captures a 24-bit address and streams bytes MSB-first on MISO, fetching each byte over a single-outstanding request/acknowledge memory port. It also answers READ STATUS (0x05) with 0x00. It sits on the FPGA side of the SPI pins, either as a flash model in system simulation or as an in-fabric ROM front end, and is oversampled by the system clock.

## Interface
- MEM_AW, 12: memory address width; SPI address bits [MEM_AW-1:0] are used and upper bits are ignored.
- SYNC_STAGES, 2: synchronizer depth on i_SPI_CLK, i_SPI_MOSI and i_SPI_CS; legal values are 2 and 3.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- i_SPI_CLK  in  1  SPI clock from master; idles low.
- i_SPI_MOSI  in  1  master-out data.
- i_SPI_CS  in  1  chip select, active low.
- o_SPI_MISO  out  1  responder data, MSB first.
- o_SPI_MISO_OE  out  1  MISO output enable, high while driving data.
- o_MEM_ADDR  out  MEM_AW  byte address for the current fetch.
- o_MEM_REQ  out  1  fetch request.
- i_MEM_DATA  in  8  fetched byte; valid in the cycle where i_MEM_ACK is high.
- i_MEM_ACK  in  1  fetch acknowledge.
- o_BUSY  out  1  high while synchronized CS is low.
- o_UNDERRUN  out  1  one-cycle pulse when a data byte was not ready in time.

## Operation
- Pin inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized SCLK (rise = prev 0, now 1; fall = prev 1, now 0), and MOSI is sampled on the detected rise.
- States: IDLE, CMD, ADDR, DATA, STATUS, IGNORE.
- IDLE → CMD on a synchronized CS falling edge; the bit counter clears to 0.
- CMD: shifts in 8 bits. At bit 7:
  - 0x03 → ADDR.
  - 0x05 → STATUS.
  - Any other value → IGNORE.
- ADDR: shifts in 24 bits. On the rise that samples address bit 0:
  - Latch o_MEM_ADDR = addr[MEM_AW-1:0].
  - Assert o_MEM_REQ on the next cycle.
  - Enter DATA.
- DATA:
  - On each detected SCLK fall at a byte boundary, load the byte buffer into the shift register, drive bit 7 and set OE.
  - On each subsequent fall, shift the next bit out.
  - When a byte is loaded, increment o_MEM_ADDR modulo 2^MEM_AW and issue a prefetch request.
- STATUS: drives 0x00 on every byte boundary indefinitely and issues no memory requests.
- IGNORE: OE stays low and no requests are issued until CS deasserts.
- Handshake:
  - o_MEM_REQ and o_MEM_ADDR are held stable until i_MEM_ACK is sampled high.
  - i_MEM_DATA is captured into the byte buffer in the ACK cycle, and REQ drops on the next cycle.
  - At most one request is outstanding.
- Underrun: if the buffer is not filled by a byte-boundary fall, shift out 0xFF and pulse o_UNDERRUN. The late data, when it arrives, is used for the following byte.
- A synchronized CS rise in any state returns to IDLE: OE low, MISO high, counters cleared.
  - An outstanding REQ stays asserted until its ACK; that data is discarded.
- Reset clears everything immediately, including an outstanding REQ.

## Timing
- Reset values:
  - o_SPI_MISO = 1, o_SPI_MISO_OE = 0.
  - o_MEM_ADDR = 0, o_MEM_REQ = 0.
  - o_BUSY = 0, o_UNDERRUN = 0.
  - State = IDLE.
- Pin-to-detect latency is SYNC_STAGES+1 clk cycles. MISO updates 1 cycle after a detected fall, i.e. SYNC_STAGES+2 cycles after the pin fall.
- SCLK high and low times must each be at least SYNC_STAGES+4 clk cycles. CS setup to the first SCLK rise must be at least SYNC_STAGES+2 cycles.
- The first data byte has a fetch budget from REQ assert to the fall after address bit 0: ACK must arrive within half-SCLK − 3 cycles. Subsequent bytes have about 8 SCLK periods of budget.
- o_BUSY follows synchronized CS with SYNC_STAGES cycles of latency.
- If SCLK rise and CS rise are detected in the same cycle, CS wins and no bit is sampled.

## Test plan
- READ 0x03, address 0x000123, memory returns the low address byte with ACK after 2 cycles, 4 bytes clocked → MISO 0x23, 0x24, 0x25, 0x26; REQ addresses 0x123–0x127; no underrun.
- MEM_AW=12, address 0xABCFFF, 2 bytes → o_MEM_ADDR 0xFFF then 0x000; upper address bits ignored.
- STATUS 0x05, 3 bytes → MISO 0x00 ×3 with OE high during data; o_MEM_REQ never asserts.
- Command 0xAB followed by 16 clocks → OE stays 0 and no REQ; a following 0x03 transaction at address 0x010 returns the correct byte.
- ACK delayed beyond the first-byte budget → first byte 0xFF, o_UNDERRUN pulses once, second byte = data for the first address.
- CS deasserted after 20 address bits, then reset asserted during a later DATA phase with REQ high → both abort to IDLE with REQ cleared; the next transaction completes correctly.
